// File: rtl/issue_ctrl_if.sv
// Fetch / issue / writeback signal bundle between the front end and issue_ctrl.
interface issue_ctrl_if #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
);
  logic                if_valid;
  logic [31:0]         if_instr;
  logic                id_ready;
  logic                flush;
  logic                ex_ready;
  logic                issue_valid;
  logic [31:0]         issue_instr;
  logic [4:0]          issue_rs1;
  logic [4:0]          issue_rs2;
  logic [4:0]          issue_rd;
  logic                issue_illegal;
  logic                wb_valid;
  logic [4:0]          wb_rd;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output if_valid, if_instr, flush, ex_ready, wb_valid, wb_rd,
    input  id_ready, issue_valid, issue_instr, issue_rs1, issue_rs2, issue_rd,
           issue_illegal, busy_vec, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, flush, ex_ready, wb_valid, wb_rd,
    output id_ready, issue_valid, issue_instr, issue_rs1, issue_rs2, issue_rd,
           issue_illegal, busy_vec, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl.sv
// Single-entry decode/issue stage with a register scoreboard and a saturating
// hazard-stall counter.
module issue_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_ctrl_if.slave  bus
);

  logic                r_hold_valid;
  logic [31:0]         r_hold_instr;
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic        w_use_rs1, w_use_rs2, w_use_rd, w_illegal;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_busy32, w_busy_nxt;
  logic        w_hazard, w_issue_valid, w_fire, w_id_ready;

  assign w_rs1 = r_hold_instr[19:15];
  assign w_rs2 = r_hold_instr[24:20];
  assign w_rd  = r_hold_instr[11:7];

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_illegal = 1'b0;
    case (r_hold_instr[6:0])
      7'b0110011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: w_use_rd = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  // Widen to 32 so any 5-bit register index is a legal lookup; x0 reads idle.
  always_comb begin
    w_busy32                 = '0;
    w_busy32[NUM_REGS-1:0]   = r_busy;
    w_busy32[0]              = 1'b0;
  end

  assign w_hazard = r_hold_valid &
                    ((w_use_rs1 & w_busy32[w_rs1]) |
                     (w_use_rs2 & w_busy32[w_rs2]) |
                     (w_use_rd  & w_busy32[w_rd]));

  assign w_issue_valid = r_hold_valid & ~w_hazard & ~bus.flush;
  assign w_fire        = w_issue_valid & bus.ex_ready;
  assign w_id_ready    = (~r_hold_valid | w_fire) & ~bus.flush;

  // Writeback clear first so a same-cycle issue to the same register wins.
  always_comb begin
    w_busy_nxt = w_busy32;
    if (bus.wb_valid)
      w_busy_nxt[bus.wb_rd] = 1'b0;
    if (w_fire && w_use_rd && (w_rd != 5'd0))
      w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_instr <= '0;
      r_busy       <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt[NUM_REGS-1:0];
      if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush) begin
        r_hold_valid <= 1'b0;
      end else if (bus.if_valid && w_id_ready) begin
        r_hold_valid <= 1'b1;
        r_hold_instr <= bus.if_instr;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign bus.id_ready      = w_id_ready;
  assign bus.issue_valid   = w_issue_valid;
  assign bus.issue_instr   = r_hold_instr;
  assign bus.issue_rs1     = w_rs1;
  assign bus.issue_rs2     = w_rs2;
  assign bus.issue_rd      = w_rd;
  assign bus.issue_illegal = r_hold_valid & w_illegal;
  assign bus.busy_vec      = r_busy;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule
